// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, funct constants, ALU_OP codes and mul/div FSM states
package alu_pkg;

  // alu_control codes driven to the single-cycle ALU
  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_NOR     = 4'b0101;
  localparam logic [3:0] ALU_SLT     = 4'b0110;
  localparam logic [3:0] ALU_SLTU    = 4'b0111;
  localparam logic [3:0] ALU_PASS_HI = 4'b1000;
  localparam logic [3:0] ALU_PASS_LO = 4'b1001;

  // R-type funct field values
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // main-decoder ALU classes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_SLT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // True for the four R-type ops handled by the iterative unit
  function automatic logic is_muldiv(input logic [1:0] op, input logic [5:0] f);
    return (op == ALU_OP_RTYPE) &&
           ((f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU));
  endfunction

endpackage

// File: rtl/alu_muldiv_controller_if.sv
// rtl/alu_muldiv_controller_if.sv - EX-stage bus between datapath and the ALU/mul-div controller
interface alu_muldiv_controller_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              valid_in;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [CTRL_W-1:0] alu_control;
  logic              stall;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  modport master (
    output valid_in, alu_op, funct, op_a, op_b,
    input  alu_control, stall, busy, done, hi, lo
  );

  modport slave (
    input  valid_in, alu_op, funct, op_a, op_b,
    output alu_control, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_controller_muldiv_core.sv
// rtl/alu_muldiv_controller_muldiv_core.sv - iterative shift-add / restoring divide datapath; MUL_EARLY_TERM_EN enables multiply early exit
module muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             div_zero,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int W2 = 2 * WIDTH;

  // acc: product accumulator, or remainder in its low half (raw dividend on divide by zero)
  // sh:  multiplicand shifted left each step, or divisor in its low half
  // bits: unconsumed multiplier bits, or dividend bits shifting out / quotient bits shifting in
  logic [W2-1:0]    acc;
  logic [W2-1:0]    sh;
  logic [WIDTH-1:0] bits;
  logic [CNT_W-1:0] cnt;
  logic             div_q;
  logic             dz_q;
  logic             neg_res;
  logic             neg_rem;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             early;

  assign a_neg    = is_signed & a[WIDTH-1];
  assign b_neg    = is_signed & b[WIDTH-1];
  assign a_abs    = a_neg ? -a : a;
  assign b_abs    = b_neg ? -b : b;
  assign div_zero = is_div & (b == '0);

  // Partial remainder < divisor, so the shifted value fits WIDTH+1 bits and the
  // difference's top bit is a clean borrow flag.
  assign rem_sh   = {acc[WIDTH-1:0], bits[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, sh[WIDTH-1:0]};

`ifdef MUL_EARLY_TERM_EN
  // Left-shifting multiplicand form: once no multiplier bits remain the accumulator is final.
  assign early = ~div_q & (bits == '0);
`else
  assign early = 1'b0;
`endif

  assign last = (cnt != '0) & ((cnt == CNT_W'(1)) | early);

  // load magnitudes on start, then one multiplier/quotient bit per cycle while the counter runs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sh      <= '0;
      bits    <= '0;
      cnt     <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start) begin
      div_q   <= is_div;
      dz_q    <= div_zero;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (div_zero) begin
        acc  <= W2'(a);
        sh   <= '0;
        bits <= '0;
        cnt  <= '0;
      end else if (is_div) begin
        acc  <= '0;
        sh   <= W2'(b_abs);
        bits <= a_abs;
        cnt  <= CNT_W'(WIDTH);
      end else begin
        acc  <= '0;
        sh   <= W2'(a_abs);
        bits <= b_abs;
        cnt  <= CNT_W'(WIDTH);
      end
    end else if (cnt != '0) begin
      cnt <= last ? '0 : cnt - 1'b1;
      if (div_q) begin
        if (!rem_diff[WIDTH]) begin
          acc  <= W2'(rem_diff[WIDTH-1:0]);
          bits <= {bits[WIDTH-2:0], 1'b1};
        end else begin
          acc  <= W2'(rem_sh[WIDTH-1:0]);
          bits <= {bits[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (bits[0]) acc <= acc + sh;
        sh   <= sh << 1;
        bits <= bits >> 1;
      end
    end
  end

  // sign fix-up and hi/lo mapping; MIN/-1 wraps to lo=MIN, hi=0 naturally
  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -bits : bits;
    rem  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (dz_q) begin
      res_hi = acc[WIDTH-1:0];
      res_lo = '1;
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[W2-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv_controller.sv
// rtl/alu_muldiv_controller.sv - EX-stage ALU decode, mul/div FSM, stall and HI/LO; MUL_EARLY_TERM_EN enables multiply early exit
module alu_muldiv_controller
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = $clog2(WIDTH) + 1
) (
  input logic                   clk,
  input logic                   rst,
  alu_muldiv_controller_if.slave bus
);
  state_t           state;
  logic [3:0]       ctrl;
  logic             md_op;
  logic             start;
  logic             div_zero;
  logic             core_last;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign md_op = is_muldiv(bus.alu_op, bus.funct);
  assign start = (state == ST_IDLE) & bus.valid_in & md_op;

  // single-cycle ALU select, independent of the mul/div FSM
  always_comb begin
    ctrl = ALU_ADD;
    case (bus.alu_op)
      ALU_OP_ADD: ctrl = ALU_ADD;
      ALU_OP_SUB: ctrl = ALU_SUB;
      ALU_OP_SLT: ctrl = ALU_SLT;
      default: begin
        case (bus.funct)
          F_ADD:   ctrl = ALU_ADD;
          F_SUB:   ctrl = ALU_SUB;
          F_AND:   ctrl = ALU_AND;
          F_OR:    ctrl = ALU_OR;
          F_XOR:   ctrl = ALU_XOR;
          F_NOR:   ctrl = ALU_NOR;
          F_SLT:   ctrl = ALU_SLT;
          F_SLTU:  ctrl = ALU_SLTU;
          F_MFHI:  ctrl = ALU_PASS_HI;
          F_MFLO:  ctrl = ALU_PASS_LO;
          default: ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  // funct[1] selects divide, funct[0] selects the unsigned variant
  muldiv_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (bus.funct[1]),
    .is_signed (~bus.funct[0]),
    .a         (bus.op_a),
    .b         (bus.op_b),
    .div_zero  (div_zero),
    .last      (core_last),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // mul/div sequencing with registered busy/done; hi/lo written as DONE retires
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (div_zero) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else if (bus.funct[1]) begin
              state  <= ST_DIV;
              busy_q <= 1'b1;
            end else begin
              state  <= ST_MUL;
              busy_q <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          hi_q  <= res_hi;
          lo_q  <= res_lo;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_control = CTRL_W'(ctrl);
  assign bus.stall       = start | busy_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// tb/tb_alu_muldiv_controller.sv - self-checking bench for alu_muldiv_controller
module tb_alu_muldiv_controller;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  alu_muldiv_controller_if #(.WIDTH(W), .CTRL_W(4)) bus();

  alu_muldiv_controller #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] code;
  } dec_vec_t;

  typedef struct {
    string       nm;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  dec_vec_t dec_tab[$];
  md_vec_t  md_tab[$];
  logic [3:0] rtype_map [logic [5:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0000;
    if (op == 2'b01) return 4'b0001;
    if (op == 2'b11) return 4'b0110;
    if (rtype_map.exists(f)) return rtype_map[f];
    return 4'b0000;
  endfunction

  // {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (f == FN_MULT) return sa * sb;
    if (f == FN_MULTU) return ua * ub;
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (f == FN_DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_lat(input string nm, input logic [5:0] f, input logic [31:0] b, input int lat);
    if (f[1] && b == 32'h0) chk({nm, "_lat"}, 64'(lat), 64'd1);
`ifdef MUL_EARLY_TERM_EN
    else if (!f[1]) chk({nm, "_lat_range"}, 64'(lat >= 2 && lat <= LAT), 64'd1);
`endif
    else chk({nm, "_lat"}, 64'(lat), 64'(LAT));
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input bit garbage, output int lat, output int stalls);
    bit got;
    bus.valid_in = 1'b1;
    bus.alu_op   = 2'b10;
    bus.funct    = f;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
    lat    = 0;
    stalls = bus.stall ? 1 : 0;
    got    = 1'b0;
    for (int i = 0; i < 3 * W && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) got = 1'b1;
      else begin
        if (bus.stall) stalls++;
        if (garbage) begin
          bus.valid_in = 1'($urandom_range(0, 1));
          bus.funct    = {4'b0110, 2'($urandom_range(0, 3))};
          bus.op_a     = $urandom;
          bus.op_b     = $urandom;
        end else bus.valid_in = 1'b0;
      end
    end
    bus.valid_in = 1'b0;
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_stall_in_done"}, 64'(bus.stall), 64'd0);
      chk({nm, "_hilo_before"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_single"}, 64'(bus.done), 64'd0);
    chk({nm, "_hilo"}, {bus.hi, bus.lo}, e);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    int lat, st;
    bit seen;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [1:0]  op;

    rtype_map[6'b100000] = 4'b0000;
    rtype_map[6'b100010] = 4'b0001;
    rtype_map[6'b100100] = 4'b0010;
    rtype_map[6'b100101] = 4'b0011;
    rtype_map[6'b100110] = 4'b0100;
    rtype_map[6'b100111] = 4'b0101;
    rtype_map[6'b101010] = 4'b0110;
    rtype_map[6'b101011] = 4'b0111;
    rtype_map[6'b010000] = 4'b1000;
    rtype_map[6'b010010] = 4'b1001;

    dec_tab.push_back('{2'b00, 6'b101010, 4'b0000});
    dec_tab.push_back('{2'b01, 6'b100000, 4'b0001});
    dec_tab.push_back('{2'b11, 6'b100010, 4'b0110});
    dec_tab.push_back('{2'b10, 6'b100000, 4'b0000});
    dec_tab.push_back('{2'b10, 6'b100010, 4'b0001});
    dec_tab.push_back('{2'b10, 6'b100100, 4'b0010});
    dec_tab.push_back('{2'b10, 6'b100101, 4'b0011});
    dec_tab.push_back('{2'b10, 6'b100110, 4'b0100});
    dec_tab.push_back('{2'b10, 6'b100111, 4'b0101});
    dec_tab.push_back('{2'b10, 6'b101010, 4'b0110});
    dec_tab.push_back('{2'b10, 6'b101011, 4'b0111});
    dec_tab.push_back('{2'b10, 6'b010000, 4'b1000});
    dec_tab.push_back('{2'b10, 6'b010010, 4'b1001});
    dec_tab.push_back('{2'b10, 6'b111111, 4'b0000});
    dec_tab.push_back('{2'b10, 6'b011000, 4'b0000});
    dec_tab.push_back('{2'b10, 6'b011011, 4'b0000});

    md_tab.push_back('{"mult_m3x7",   FN_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB});
    md_tab.push_back('{"divu_100_7",  FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14});
    md_tab.push_back('{"div_m7_2",    FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    md_tab.push_back('{"div_by_zero", FN_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF});
    md_tab.push_back('{"div_min_m1",  FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});
    md_tab.push_back('{"multu_max",   FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    md_tab.push_back('{"divu_by_zero",FN_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF});
    md_tab.push_back('{"mult_min_m1", FN_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000});

    bus.valid_in = 1'b0;
    bus.alu_op   = 2'b00;
    bus.funct    = 6'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    rst = 1'b0;

    // decode table
    foreach (dec_tab[i]) begin
      @(negedge clk);
      bus.alu_op = dec_tab[i].op;
      bus.funct  = dec_tab[i].f;
      #1;
      chk($sformatf("decode_%0d", i), 64'(bus.alu_control), 64'(dec_tab[i].code));
    end
    // random decode against the table model
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.alu_op = 2'($urandom_range(0, 3));
      bus.funct  = (i % 2 == 0) ? 6'($urandom_range(0, 63)) : {2'b10, 4'($urandom_range(0, 15))};
      #1;
      chk("decode_rand", 64'(bus.alu_control), 64'(ref_ctrl(bus.alu_op, bus.funct)));
    end
    @(negedge clk);

    // directed mul/div corners
    foreach (md_tab[i]) begin
      run_md(md_tab[i].nm, md_tab[i].f, md_tab[i].a, md_tab[i].b,
             {md_tab[i].hi, md_tab[i].lo}, 1'b0, lat, st);
      check_lat(md_tab[i].nm, md_tab[i].f, md_tab[i].b, lat);
      chk({md_tab[i].nm, "_stall_cycles"}, 64'(st), 64'(lat));
    end

    // MULTU 5*3: fixed latency by default, shorter with early termination
    run_md("multu_5x3", FN_MULTU, 32'd5, 32'd3, 64'd15, 1'b0, lat, st);
`ifdef MUL_EARLY_TERM_EN
    chk("multu_5x3_early", 64'(lat < LAT && lat >= 2), 64'd1);
`else
    chk("multu_5x3_lat", 64'(lat), 64'(LAT));
`endif

    // non-muldiv ops with valid_in never stall and never touch hi/lo
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom_range(0, 63));
      if (op == 2'b10 && f[5:2] == 4'b0110) f = 6'b100000;
      bus.valid_in = 1'b1;
      bus.alu_op   = op;
      bus.funct    = f;
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
      #1;
      chk("nonmd_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      chk("nonmd_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end
    bus.valid_in = 1'b0;

    // randomized ops against the arithmetic model, garbage inputs while busy
    for (int i = 0; i < 40; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      a = pick();
      b = pick();
      run_md("rand_md", f, a, b, ref_md(f, a, b), 1'b1, lat, st);
      check_lat("rand_md", f, b, lat);
      chk("rand_stall_cycles", 64'(st), 64'(lat));
    end

    // make hi/lo nonzero, then abort a MULTU with rst at N+10
    run_md("pre_rst", FN_MULTU, 32'h12345, 32'h777, ref_md(FN_MULTU, 32'h12345, 32'h777), 1'b0, lat, st);
    bus.valid_in = 1'b1;
    bus.alu_op   = 2'b10;
    bus.funct    = FN_MULTU;
    bus.op_a     = 32'hABCDEF;
    bus.op_b     = 32'h1357;
    @(posedge clk);
    @(negedge clk);
    bus.valid_in = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk("abort_stall", 64'(bus.stall), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    run_md("post_rst_6x7", FN_MULTU, 32'd6, 32'd7, 64'd42, 1'b0, lat, st);
    check_lat("post_rst_6x7", FN_MULTU, 32'd7, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
